// File: rtl/mips_cpu_state_sequencer_if.sv
// Control/status bundle between the multicycle CPU controller and its state sequencer.
// The master side is the controller/datapath and the slave side is the sequencer.
interface mips_cpu_state_sequencer_if #(
    parameter int unsigned COUNT_W = 32
);
    logic               waitrequest;
    logic               memread;
    logic               memwrite;
    logic               threecycle;
    logic               jump_taken;
    logic               target_is_zero;
    logic [2:0]         state;
    logic               active;
    logic               stall;
    logic               delay_slot;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        output waitrequest, memread, memwrite, threecycle, jump_taken, target_is_zero,
        input  state, active, stall, delay_slot, instr_count
    );

    modport slave (
        input  waitrequest, memread, memwrite, threecycle, jump_taken, target_is_zero,
        output state, active, stall, delay_slot, instr_count
    );
endinterface

// File: rtl/mips_cpu_state_sequencer.sv
// Multicycle state sequencer: FETCH/DECODE/EXEC1/EXEC2 stepping, waitrequest freeze,
// branch delay-slot tracking, halt after a jump to address 0, retired-instruction count.
module mips_cpu_state_sequencer #(
    parameter int unsigned COUNT_W = 32
) (
    input logic                     clk,
    input logic                     reset,
    mips_cpu_state_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_HALTED = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC1  = 3'd3,
        S_EXEC2  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               active_q, active_d;
    logic               delay_slot_q, delay_slot_d;
    logic               halt_pending_q, halt_pending_d;
    logic               jl_q, jl_d;
    logic               zl_q, zl_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               stall_c;
    logic               jl_n;
    logic               zl_n;
    logic               retire;

    // active_q is a register, so stall has no combinational path from state.
    always_comb stall_c = active_q & (bus.memread | bus.memwrite) & bus.waitrequest;

    always_comb begin
        state_d        = state_q;
        active_d       = active_q;
        delay_slot_d   = delay_slot_q;
        halt_pending_d = halt_pending_q;
        jl_d           = jl_q;
        zl_d           = zl_q;
        count_d        = count_q;
        retire         = 1'b0;

        // Jump sampling folds into the retire decision of the same edge.
        jl_n = jl_q | (bus.jump_taken & ~delay_slot_q);
        zl_n = (bus.jump_taken & ~delay_slot_q) ? bus.target_is_zero : zl_q;

        if (!stall_c) begin
            unique case (state_q)
                S_HALTED: state_d = S_HALTED;
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: state_d = S_EXEC1;
                S_EXEC1: begin
                    jl_d = jl_n;
                    zl_d = zl_n;
                    if (bus.threecycle) retire = 1'b1;
                    else                state_d = S_EXEC2;
                end
                S_EXEC2: begin
                    jl_d   = jl_n;
                    zl_d   = zl_n;
                    retire = 1'b1;
                end
                default: begin
                    state_d = S_FETCH;
                    jl_d    = 1'b0;
                    zl_d    = 1'b0;
                end
            endcase

            if (retire) begin
                count_d = count_q + 1'b1;
                jl_d    = 1'b0;
                zl_d    = 1'b0;
                state_d = S_FETCH;
                if (delay_slot_q) begin
                    delay_slot_d = 1'b0;
                    if (halt_pending_q) begin
                        state_d        = S_HALTED;
                        active_d       = 1'b0;
                        halt_pending_d = 1'b0;
                    end
                end else if (jl_n) begin
                    delay_slot_d   = 1'b1;
                    halt_pending_d = zl_n;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_FETCH;
            active_q       <= 1'b1;
            delay_slot_q   <= 1'b0;
            halt_pending_q <= 1'b0;
            jl_q           <= 1'b0;
            zl_q           <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            active_q       <= active_d;
            delay_slot_q   <= delay_slot_d;
            halt_pending_q <= halt_pending_d;
            jl_q           <= jl_d;
            zl_q           <= zl_d;
            count_q        <= count_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.active      = active_q;
    assign bus.stall       = stall_c;
    assign bus.delay_slot  = delay_slot_q;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_mips_cpu_state_sequencer.sv
// Self-checking bench: instruction-level reference model driven by directed and random instructions.
module tb_mips_cpu_state_sequencer;

    localparam int unsigned CW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mips_cpu_state_sequencer_if #(.COUNT_W(CW)) bus ();

    mips_cpu_state_sequencer #(.COUNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state, tracked per instruction rather than per cycle.
    int unsigned m_count;
    bit          m_ds;
    bit          m_hp;
    bit          m_halted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive_idle();
        bus.memread        = 1'b0;
        bus.memwrite       = 1'b0;
        bus.waitrequest    = 1'b0;
        bus.threecycle     = 1'b0;
        bus.jump_taken     = 1'b0;
        bus.target_is_zero = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_count = 0; m_ds = 0; m_hp = 0; m_halted = 0;
        #1;
        chk("rst_state", {29'd0, bus.state}, 32'd1);
        chk("rst_active", {31'd0, bus.active}, 32'd1);
        chk("rst_ds", {31'd0, bus.delay_slot}, 32'd0);
        chk("rst_count", {28'd0, bus.instr_count}, 32'd0);
    endtask

    // One instruction: phase 1 fetch reads memory with fw waits; phase 3 optionally
    // accesses memory with w3 waits. Outputs are checked every cycle at posedge+2.
    task automatic run_instr(input bit tc, input bit jmp, input bit zro,
                             input int unsigned fw, input bit m3, input int unsigned w3);
        int unsigned nph;
        bit          mem;
        bit          wr;
        int unsigned w;
        nph = tc ? 3 : 4;
        wr  = 1'($urandom);
        chk("count_at_fetch", {28'd0, bus.instr_count}, m_count);
        for (int unsigned p = 1; p <= nph; p++) begin
            mem = (p == 1) || (p == 3 && m3);
            w   = (p == 1) ? fw : ((p == 3 && m3) ? w3 : 0);
            for (int unsigned k = 0; k <= w; k++) begin
                bus.memread        = mem && !(p == 3 && wr);
                bus.memwrite       = mem && (p == 3 && wr);
                bus.waitrequest    = mem ? (k < w) : 1'($urandom);
                bus.threecycle     = tc;
                bus.jump_taken     = (p >= 3) ? jmp : 1'($urandom);
                bus.target_is_zero = zro;
                #1;
                chk("state", {29'd0, bus.state}, p);
                chk("stall", {31'd0, bus.stall}, (mem && k < w) ? 32'd1 : 32'd0);
                chk("delay_slot", {31'd0, bus.delay_slot}, {31'd0, m_ds});
                chk("active", {31'd0, bus.active}, 32'd1);
                @(posedge clk); #1;
            end
        end
        drive_idle();
        m_count = (m_count + 1) % (1 << CW);
        if (m_ds) begin
            m_ds = 0;
            if (m_hp) begin
                m_hp = 0;
                m_halted = 1;
            end
        end else if (jmp) begin
            m_ds = 1;
            m_hp = zro;
        end
    endtask

    task automatic check_halted(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            bus.memread     = 1'($urandom);
            bus.memwrite    = 1'($urandom);
            bus.waitrequest = 1'b1;
            bus.jump_taken  = 1'($urandom);
            bus.threecycle  = 1'($urandom);
            #1;
            chk("halt_state", {29'd0, bus.state}, 32'd0);
            chk("halt_active", {31'd0, bus.active}, 32'd0);
            chk("halt_stall", {31'd0, bus.stall}, 32'd0);
            chk("halt_count", {28'd0, bus.instr_count}, m_count);
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        do_reset();

        // ADDU then LW with fetch and EXEC1 waits
        run_instr(1, 0, 0, 0, 0, 0);
        run_instr(0, 0, 0, 2, 1, 3);
        chk("count_after_lw", {28'd0, bus.instr_count}, 32'd2);

        // JR to zero plus delay slot, then halt
        do_reset();
        run_instr(1, 1, 1, 0, 0, 0);
        run_instr(1, 0, 0, 1, 0, 0);
        check_halted(20);
        chk("halt_count2", {28'd0, bus.instr_count}, 32'd2);
        do_reset();

        // Taken branch to non-zero target, delay slot, then ordinary instruction
        run_instr(0, 1, 0, 0, 1, 1);
        run_instr(1, 1, 1, 0, 0, 0);
        run_instr(0, 0, 0, 0, 0, 0);

        // Reset while stalled in EXEC2
        bus.threecycle = 1'b0;
        for (int unsigned p = 1; p <= 3; p++) begin
            #1; chk("pre_rst_state", {29'd0, bus.state}, p);
            @(posedge clk); #1;
        end
        bus.memwrite    = 1'b1;
        bus.waitrequest = 1'b1;
        #1;
        chk("ex2_stall_state", {29'd0, bus.state}, 32'd4);
        chk("ex2_stall", {31'd0, bus.stall}, 32'd1);
        drive_idle();
        bus.memwrite    = 1'b1;
        bus.waitrequest = 1'b1;
        do_reset();
        drive_idle();

        // Counter wrap with 4-bit width
        for (int i = 0; i < 17; i++) run_instr(1, 0, 0, 0, 0, 0);
        chk("wrap_count", {28'd0, bus.instr_count}, 32'd1);

        // Random instruction stream
        for (int i = 0; i < 60; i++) begin
            if (m_halted) begin
                check_halted(3);
                do_reset();
            end
            run_instr(1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                      $urandom_range(0, 2), 1'($urandom), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
